// File: rtl/fetch_queue.sv
// Instruction fetch queue between fetch and decode: DEPTH-entry FIFO of {pc, instr, except}
// with full flush and delay-slot-preserving flush. Optional same-cycle bypass under FETCHQ_BYPASS_EN.
module fetch_queue #(
   parameter int PC_W    = 32,
   parameter int INSTR_W = 32,
   parameter int EXC_W   = 8,
   parameter int DEPTH   = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push_valid,
   output logic                       push_ready,
   input  logic [PC_W-1:0]            push_pc,
   input  logic [INSTR_W-1:0]         push_instr,
   input  logic [EXC_W-1:0]           push_except,
   output logic                       pop_valid,
   input  logic                       pop_ready,
   output logic [PC_W-1:0]            pop_pc,
   output logic [INSTR_W-1:0]         pop_instr,
   output logic [EXC_W-1:0]           pop_except,
   input  logic                       flush,
   input  logic                       flush_keep,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW  = $clog2(DEPTH);
   localparam int CW  = AW + 1;
   localparam int E_W = PC_W + INSTR_W + EXC_W;

   logic [E_W-1:0] r_mem [DEPTH];
   logic [AW-1:0]  r_rd_ptr, r_wr_ptr;
   logic [CW-1:0]  r_count;

   logic [AW-1:0]  w_rd_ptr_nxt, w_wr_ptr_nxt;
   logic [CW-1:0]  w_count_nxt;
   logic           w_empty, w_full, w_bypass, w_push, w_pop, w_store, w_deq;
   logic [E_W-1:0] w_head;

   assign w_empty = (r_count == {CW{1'b0}});
   assign w_full  = (r_count == CW'(DEPTH));

`ifdef FETCHQ_BYPASS_EN
   assign w_bypass = w_empty & push_valid & ~flush & ~flush_keep & rst;
`else
   assign w_bypass = 1'b0;
`endif

   assign push_ready = ~w_full & ~flush & ~flush_keep & rst;
   assign pop_valid  = ~w_empty | w_bypass;
   assign w_push     = push_valid & push_ready;
   assign w_pop      = pop_valid & pop_ready;
   // A bypassed entry consumed in the same cycle never touches the array.
   assign w_store    = w_push & ~(w_bypass & pop_ready);
   assign w_deq      = w_pop & ~w_empty;

   // Head entry mux: bypass path, stored head, or zeros when nothing is valid.
   always_comb begin
      w_head = {E_W{1'b0}};
      if (w_bypass) begin
         w_head = {push_pc, push_instr, push_except};
      end else if (!w_empty) begin
         w_head = r_mem[r_rd_ptr];
      end else begin
         w_head = {E_W{1'b0}};
      end
   end

   assign pop_pc     = w_head[E_W-1 -: PC_W];
   assign pop_instr  = w_head[EXC_W +: INSTR_W];
   assign pop_except = w_head[EXC_W-1:0];
   assign count      = r_count;

   // Next-state for pointers and occupancy; flush dominates flush_keep.
   always_comb begin
      w_rd_ptr_nxt = r_rd_ptr;
      w_wr_ptr_nxt = r_wr_ptr;
      w_count_nxt  = r_count;
      if (flush) begin
         w_rd_ptr_nxt = {AW{1'b0}};
         w_wr_ptr_nxt = {AW{1'b0}};
         w_count_nxt  = {CW{1'b0}};
      end else if (flush_keep) begin
         if (w_empty) begin
            w_count_nxt = r_count;
         end else if (w_deq) begin
            w_rd_ptr_nxt = r_rd_ptr + AW'(1);
            w_wr_ptr_nxt = r_rd_ptr + AW'(1);
            w_count_nxt  = {CW{1'b0}};
         end else begin
            w_wr_ptr_nxt = r_rd_ptr + AW'(1);
            w_count_nxt  = CW'(1);
         end
      end else begin
         if (w_store) begin
            w_wr_ptr_nxt = r_wr_ptr + AW'(1);
         end else begin
            w_wr_ptr_nxt = r_wr_ptr;
         end
         if (w_deq) begin
            w_rd_ptr_nxt = r_rd_ptr + AW'(1);
         end else begin
            w_rd_ptr_nxt = r_rd_ptr;
         end
         case ({w_store, w_deq})
            2'b10:   w_count_nxt = r_count + CW'(1);
            2'b01:   w_count_nxt = r_count - CW'(1);
            default: w_count_nxt = r_count;
         endcase
      end
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rd_ptr <= {AW{1'b0}};
         r_wr_ptr <= {AW{1'b0}};
         r_count  <= {CW{1'b0}};
      end else begin
         r_rd_ptr <= w_rd_ptr_nxt;
         r_wr_ptr <= w_wr_ptr_nxt;
         r_count  <= w_count_nxt;
      end
   end

   // Entry storage, intentionally not reset.
   always_ff @(posedge clk) begin
      if (w_store) begin
         r_mem[r_wr_ptr] <= {push_pc, push_instr, push_except};
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// Randomised and directed bench for fetch_queue, checked against a queue-based model.
module tb_fetch_queue;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        push_valid = 1'b0, pop_ready = 1'b0, flush = 1'b0, flush_keep = 1'b0;
   logic        push_ready, pop_valid;
   logic [31:0] push_pc = 32'd0, push_instr = 32'd0, pop_pc, pop_instr;
   logic [7:0]  push_except = 8'd0, pop_except;
   logic [2:0]  count;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] ins;
      logic [7:0]  ex;
   } ent_t;

   ent_t q[$];
   int   n_vec = 0;
   int   n_err = 0;
   logic exp_pr, exp_pv, exp_byp;

   fetch_queue #(.PC_W(32), .INSTR_W(32), .EXC_W(8), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .push_valid(push_valid), .push_ready(push_ready),
      .push_pc(push_pc), .push_instr(push_instr), .push_except(push_except),
      .pop_valid(pop_valid), .pop_ready(pop_ready),
      .pop_pc(pop_pc), .pop_instr(pop_instr), .pop_except(pop_except),
      .flush(flush), .flush_keep(flush_keep), .count(count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Apply inputs just after a falling edge and compare all outputs with the model.
   task automatic drive(input logic pv, input logic [31:0] pc, input logic pr,
                        input logic fl, input logic fk);
      ent_t e;
      push_valid  = pv;
      push_pc     = pc;
      push_instr  = $urandom;
      push_except = 8'($urandom);
      pop_ready   = pr;
      flush       = fl;
      flush_keep  = fk;
      #1;
      exp_pr = rst && (q.size() != DEPTH) && !fl && !fk;
`ifdef FETCHQ_BYPASS_EN
      exp_byp = rst && (q.size() == 0) && pv && !fl && !fk;
`else
      exp_byp = 1'b0;
`endif
      exp_pv = rst && ((q.size() != 0) || exp_byp);
      if (exp_byp)           e = '{pc: pc, ins: push_instr, ex: push_except};
      else if (q.size() > 0) e = q[0];
      else                   e = '0;
      chk("push_ready", 64'(push_ready), 64'(exp_pr));
      chk("pop_valid",  64'(pop_valid),  64'(exp_pv));
      chk("pop_pc",     64'(pop_pc),     64'(e.pc));
      chk("pop_instr",  64'(pop_instr),  64'(e.ins));
      chk("pop_except", 64'(pop_except), 64'(e.ex));
      chk("count",      64'(count),      64'(q.size()));
   endtask

   // Move the model to its post-edge state and step to the next falling edge.
   task automatic advance();
      logic push_acc, pop_acc;
      ent_t e0;
      push_acc = push_valid && exp_pr;
      pop_acc  = exp_pv && pop_ready;
      if (flush) begin
         q.delete();
      end else if (flush_keep) begin
         if (q.size() != 0) begin
            e0 = q[0];
            q.delete();
            if (!pop_acc) q.push_back(e0);
         end
      end else if (exp_byp && pop_ready) begin
         // entry passes straight through
      end else begin
         if (pop_acc && q.size() != 0) void'(q.pop_front());
         if (push_acc) q.push_back('{pc: push_pc, ins: push_instr, ex: push_except});
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic step(input logic pv, input logic [31:0] pc, input logic pr,
                       input logic fl, input logic fk);
      drive(pv, pc, pr, fl, fk);
      advance();
   endtask

   // Asynchronous reset pulse starting mid-cycle.
   task automatic do_reset();
      rst = 1'b0;
      #1;
      chk("rst_push_ready", 64'(push_ready), 64'd0);
      chk("rst_pop_valid",  64'(pop_valid),  64'd0);
      chk("rst_count",      64'(count),      64'd0);
      chk("rst_pop_pc",     64'(pop_pc),     64'd0);
      q.delete();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      push_valid = 1'b0; flush = 1'b0; flush_keep = 1'b0;
      #1;
      chk("rel_push_ready", 64'(push_ready), 64'd1);
      chk("rel_pop_valid",  64'(pop_valid),  64'd0);
   endtask

   initial begin
      @(negedge clk);
      do_reset();

      // Fill to full, reject fifth push, drain in order.
      for (int i = 0; i < 4; i++) step(1'b1, 32'hBFC0_0000 + 32'(4 * i), 1'b0, 1'b0, 1'b0);
      #1;
      chk("fill_count", 64'(count), 64'd4);
      chk("fill_push_ready", 64'(push_ready), 64'd0);
      step(1'b1, 32'hBFC0_0010, 1'b0, 1'b0, 1'b0);
      chk("fifth_count", 64'(count), 64'd4);
      for (int i = 0; i < 4; i++) begin
         chk("drain_pc", 64'(pop_pc), 64'(32'hBFC0_0000 + 32'(4 * i)));
         step(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
      end
      chk("drain_count", 64'(count), 64'd0);

      // Full with simultaneous pop: push rejected.
      for (int i = 0; i < 4; i++) step(1'b1, 32'h300 + 32'(4 * i), 1'b0, 1'b0, 1'b0);
      step(1'b1, 32'h400, 1'b1, 1'b0, 1'b0);
      chk("fullpop_count", 64'(count), 64'd3);
      chk("fullpop_head", 64'(pop_pc), 64'h304);
      step(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
      chk("flush_count", 64'(count), 64'd0);

      // Continuous push+pop at count 2 across pointer wrap.
      for (int i = 0; i < 2; i++) step(1'b1, 32'h500 + 32'(4 * i), 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         step(1'b1, 32'h508 + 32'(4 * i), 1'b1, 1'b0, 1'b0);
         chk("wrap_count", 64'(count), 64'd2);
      end
      chk("wrap_head", 64'(pop_pc), 64'h528);
      step(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);

      // flush_keep without and with a same-cycle pop.
      for (int i = 0; i < 3; i++) step(1'b1, 32'h100 + 32'(4 * i), 1'b0, 1'b0, 1'b0);
      step(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
      chk("fk_count", 64'(count), 64'd1);
      chk("fk_head", 64'(pop_pc), 64'h100);
      step(1'b1, 32'h10C, 1'b0, 1'b0, 1'b0);
      chk("fk_push_count", 64'(count), 64'd2);
      step(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
      chk("fk_next_head", 64'(pop_pc), 64'h10C);
      step(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b1, 32'h100 + 32'(4 * i), 1'b0, 1'b0, 1'b0);
      step(1'b0, 32'd0, 1'b1, 1'b0, 1'b1);
      chk("fkpop_count", 64'(count), 64'd0);
      chk("fkpop_valid", 64'(pop_valid), 64'd0);

      // flush and flush_keep together with a push offered.
      for (int i = 0; i < 3; i++) step(1'b1, 32'h600 + 32'(4 * i), 1'b0, 1'b0, 1'b0);
      step(1'b1, 32'h60C, 1'b0, 1'b1, 1'b1);
      chk("both_count", 64'(count), 64'd0);
      chk("both_valid", 64'(pop_valid), 64'd0);

      // Empty-queue push with pop_ready: bypass versus latency-1 path.
      drive(1'b1, 32'h200, 1'b1, 1'b0, 1'b0);
`ifdef FETCHQ_BYPASS_EN
      chk("byp_valid", 64'(pop_valid), 64'd1);
      chk("byp_pc", 64'(pop_pc), 64'h200);
      advance();
      chk("byp_count", 64'(count), 64'd0);
`else
      chk("nobyp_valid", 64'(pop_valid), 64'd0);
      advance();
      chk("nobyp_pc", 64'(pop_pc), 64'h200);
      chk("nobyp_count", 64'(count), 64'd1);
`endif
      step(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);

      // Randomised traffic with occasional flushes and resets.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(99) == 0) begin
            do_reset();
         end else begin
            step(($urandom_range(3) != 0), $urandom, 1'($urandom),
                 ($urandom_range(15) == 0), ($urandom_range(15) == 0));
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised instruction fetch queue between the fetch and decode stages of the CPU pipeline. It replaces the single IF/ID pipeline register with a DEPTH-entry FIFO of {pc, instr, except} so that instruction-SRAM latency and decode stalls are decoupled. It supports full flush on exception/eret redirect and a delay-slot-preserving flush on taken branches/jumps.

## Interface
Parameters:
- PC_W, 32, PC width
- INSTR_W, 32, instruction width
- EXC_W, 8, fetch-exception code width (bit EXC_W-1 = fetch address error)
- DEPTH, 4, entries; power of two, ≥2

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low
- push_valid  in  1  fetch has an instruction
- push_ready  out  1  queue accepts push this cycle
- push_pc  in  PC_W  PC of pushed instruction
- push_instr  in  INSTR_W  pushed instruction word
- push_except  in  EXC_W  fetch exception bits
- pop_valid  out  1  head entry available to decode
- pop_ready  in  1  decode consumes head this cycle
- pop_pc  out  PC_W  head PC
- pop_instr  out  INSTR_W  head instruction
- pop_except  out  EXC_W  head exception bits
- flush  in  1  discard all entries (exception/eret redirect)
- flush_keep  in  1  discard all but oldest entry (branch delay slot)
- count  out  $clog2(DEPTH)+1  occupancy

## Operation
- Storage: DEPTH-entry register array, rd_ptr/wr_ptr of $clog2(DEPTH) bits wrapping modulo DEPTH, separate count register. Array contents not reset.
- push accepted ⇔ push_valid & push_ready; push_ready = (count != DEPTH) & ~flush & ~flush_keep & rst.
- pop performed ⇔ pop_valid & pop_ready; pop_valid = (count != 0).
- pop_pc/pop_instr/pop_except = array[rd_ptr] when pop_valid, else all-zero.
- Full: push_ready=0 even if a pop occurs same cycle (no same-cycle slot reuse).
- Simultaneous push and pop at 0<count<DEPTH: count unchanged, both pointers advance.
- flush (priority over flush_keep): next state count=0, rd_ptr=wr_ptr=0; pop and push that cycle have no effect on state (pop_valid still reflects pre-flush head; decode must ignore it).
- flush_keep: if count==0 → unchanged; if head popped same cycle → count=0, rd_ptr=wr_ptr=rd_ptr+1; else count=1, wr_ptr=rd_ptr+1, rd_ptr unchanged.
- Reset asserted at any time (including mid-flush): pointers and count 0 immediately; push_ready=0, pop_valid=0, pop_* = 0, count=0 while rst low.

## Timing
- Default: pushed entry visible at pop one cycle after acceptance (latency 1); throughput 1 push + 1 pop per cycle.
- count, pointers registered; push_ready, pop_valid, pop_* combinational from registers (plus flush inputs for push_ready).
- flush/flush_keep take effect on the clock edge of the cycle they are high; push_ready is low in that same cycle.
- First cycle after rst release: push_ready=1, pop_valid=0.

## Configuration
- FETCHQ_BYPASS_EN defined: when count==0 and push_valid & ~flush & ~flush_keep, pop_valid=1 and pop_* = push_* combinationally (latency 0); if pop_ready also high, entry is consumed and not stored (count stays 0); otherwise stored normally.
- Not defined: no bypass; pop_valid depends only on count; latency exactly 1.

## Test plan
- Reset/fill: release rst, push pc 0xBFC00000..0xBFC0000C (4 entries, pop_ready=0) → count=4, push_ready=0, fifth push ignored; pop 4 → pcs in order, count=0.
- Wrap: DEPTH=4, 10 cycles continuous push+pop at count=2 → pop order matches push order across pointer wrap, count constant 2.
- Full + pop: count=4, push_valid=1, pop_ready=1 → one pop, push rejected, count=3 next cycle.
- flush_keep: entries pc 0x100,0x104,0x108, pop_ready=0, flush_keep=1 → next cycle count=1, head pc 0x100; next push lands behind it. Repeat with pop_ready=1 → count=0.
- flush vs flush_keep both high with 3 entries and push_valid=1 → count=0, push_ready=0 that cycle, pop_valid=0 next cycle.
- Bypass (FETCHQ_BYPASS_EN): empty, push pc 0x200 with pop_ready=1 → same-cycle pop_pc=0x200, count stays 0; without macro → pop_valid=0 that cycle, pop_pc=0x200 next cycle.
